// File: rtl/led_pwm_ctrl_pkg.sv
// Shared constants, types and helpers for the LED PWM command consumer.
// Optional build macro used by the design: LED_FADE_EN (gradual level fade).
package led_pwm_ctrl_pkg;

    // Field widths of a decoded SPI frame
    localparam int CMD_BITS     = 8;
    localparam int ADDR_BITS    = 8;
    localparam int PAYLOAD_BITS = 8;

    // Command opcodes
    localparam logic [CMD_BITS-1:0] CMD_NOP      = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_LED_SET  = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_LED_READ = 8'h02;

    // PWM resolution and brightness ceiling (percent)
    localparam int PWM_STEPS    = 100;
    localparam int BRIGHT_MAX   = 100;
    localparam int PWM_CNT_BITS = 7;

    // Frame tracking FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_COMMIT = 2'd2
    } frame_state_t;

    // Saturate a requested brightness to BRIGHT_MAX
    function automatic logic [7:0] clamp_pct(input logic [PAYLOAD_BITS-1:0] pct);
        return (pct > PAYLOAD_BITS'(BRIGHT_MAX)) ? 8'(BRIGHT_MAX) : 8'(pct);
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_pwm_channel.sv
// One LED channel: brightness target, effective level and PWM compare.
// With LED_FADE_EN the level walks one step toward the target on each
// fade step; otherwise the level follows the target on every write.
module led_pwm_ctrl_pwm_channel
    import led_pwm_ctrl_pkg::*;
(
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [7:0]              i_wr_level,
    input  logic [PWM_CNT_BITS-1:0] i_pwm_cnt,
    input  logic                    i_fade_step,
    output logic [7:0]              o_target,
    output logic                    o_led
);

    logic [7:0] r_target;
    logic [7:0] r_level;
    logic       r_led;

    // Brightness target, written on each accepted SET
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_target <= '0;
        end else if (i_wr_en) begin
            r_target <= i_wr_level;
        end
    end

`ifdef LED_FADE_EN
    // Walk the level one step toward the target on each fade step;
    // a retarget mid-fade simply changes the direction/endpoint
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (i_fade_step) begin
            if (r_level < r_target) begin
                r_level <= r_level + 8'd1;
            end else if (r_level > r_target) begin
                r_level <= r_level - 8'd1;
            end
        end
    end
`else
    logic w_unused_fade_step;
    assign w_unused_fade_step = i_fade_step;

    // Level tracks the target immediately on each write
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (i_wr_en) begin
            r_level <= i_wr_level;
        end
    end
`endif

    // Registered PWM compare: level 0 never lights, level 100 always lights
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= ({1'b0, i_pwm_cnt} < r_level);
        end
    end

    assign o_target = r_target;
    assign o_led    = r_led;

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED PWM command consumer sitting behind the SPI slave.
// Decodes completed frames into per-LED brightness registers, returns the
// addressed brightness to the slave, and drives one PWM output per LED.
// Optional build macro: LED_FADE_EN (level fades toward target every
// FADE_DIV PWM periods instead of jumping at commit).
//
// Slave interface handshake: i_rx_dv is high while chip select is idle and
// low while a frame is shifting; its rising edge marks the frame's fields
// (i_cmd/i_addr/i_payload) as complete and they are captured on that cycle.
// i_rx_addr_dv rising during a frame marks i_addr valid for a read; the
// slave loads o_tx_payload one cycle later, so o_tx_payload is combinational.
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PRESCALE = 1250,
    parameter int FADE_DIV = 4
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic [CMD_BITS-1:0]     i_cmd,
    input  logic [ADDR_BITS-1:0]    i_addr,
    input  logic [PAYLOAD_BITS-1:0] i_payload,
    input  logic                    i_rx_dv,
    input  logic                    i_rd_bypass,
    input  logic                    i_rx_addr_dv,
    output logic [7:0]              o_tx_payload,
    output logic [NUM_LEDS-1:0]     o_led,
    output logic                    o_wr_strobe,
    output logic                    o_rd_strobe,
    output logic                    o_err,
    output logic [1:0]              o_dbg_state
);

    localparam int PS_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    frame_state_t                r_state;
    frame_state_t                w_next_state;
    logic                        r_rx_dv_q;
    logic                        r_addr_dv_q;
    logic                        r_armed;
    logic                        r_rd_done;
    logic [CMD_BITS-1:0]         r_cmd;
    logic [ADDR_BITS-1:0]        r_addr;
    logic [PAYLOAD_BITS-1:0]     r_payload;
    logic                        r_wr_strobe;
    logic                        r_rd_strobe;
    logic                        r_err;
    logic [PS_BITS-1:0]          r_ps;
    logic [PWM_CNT_BITS-1:0]     r_pwm_cnt;

    logic                        w_rx_rise;
    logic                        w_addr_dv_rise;
    logic                        w_rd_addr_ok;
    logic                        w_commit_wr;
    logic                        w_commit_err;
    logic                        w_rd_hit;
    logic                        w_rd_err;
    logic                        w_tick;
    logic                        w_wrap;
    logic                        w_fade_step;
    logic [7:0]                  w_wr_level;
    logic [7:0]                  w_tx_payload;
    logic [7:0]                  w_target [NUM_LEDS];
    logic [NUM_LEDS-1:0]         w_led;

    assign w_rx_rise      = i_rx_dv && !r_rx_dv_q;
    assign w_addr_dv_rise = i_rx_addr_dv && !r_addr_dv_q;
    assign w_rd_addr_ok   = (i_addr < ADDR_BITS'(NUM_LEDS));
    assign w_wr_level     = clamp_pct(r_payload);

    // Edge history; rx_dv history resets high so leaving reset is not an edge.
    // r_armed blocks a frame that was already in flight across a reset:
    // a new frame only starts once rx_dv has been seen idle-high.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_rx_dv_q   <= 1'b1;
            r_addr_dv_q <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_rx_dv_q   <= i_rx_dv;
            r_addr_dv_q <= i_rx_addr_dv;
            r_armed     <= r_armed | i_rx_dv;
        end
    end

    // Frame FSM state register
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Frame FSM next state, read service in BUSY and decode in COMMIT
    always_comb begin
        w_next_state = r_state;
        w_commit_wr  = 1'b0;
        w_commit_err = 1'b0;
        w_rd_hit     = 1'b0;
        w_rd_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_rx_dv && r_armed) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_rx_rise) begin
                    w_next_state = ST_COMMIT;
                end
                if (w_addr_dv_rise && i_rd_bypass && !r_rd_done) begin
                    w_rd_hit = 1'b1;
                    w_rd_err = !w_rd_addr_ok;
                end
            end
            ST_COMMIT: begin
                w_next_state = ST_IDLE;
                if (r_cmd == CMD_LED_SET) begin
                    if (r_addr < ADDR_BITS'(NUM_LEDS)) begin
                        w_commit_wr = 1'b1;
                    end else begin
                        w_commit_err = 1'b1;
                    end
                end else if ((r_cmd != CMD_LED_READ) && (r_cmd != CMD_NOP)) begin
                    w_commit_err = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture frame fields on the rx_dv rising cycle for use in COMMIT
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_cmd     <= '0;
            r_addr    <= '0;
            r_payload <= '0;
        end else if ((r_state == ST_BUSY) && w_rx_rise) begin
            r_cmd     <= i_cmd;
            r_addr    <= i_addr;
            r_payload <= i_payload;
        end
    end

    // One read strobe per frame; re-armed whenever the FSM is idle
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_rd_done <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_rd_done <= 1'b0;
        end else if (w_rd_hit) begin
            r_rd_done <= 1'b1;
        end
    end

    // Registered one-cycle status pulses
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_wr_strobe <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_strobe <= w_commit_wr;
            r_rd_strobe <= w_rd_hit;
            r_err       <= w_commit_err | w_rd_err;
        end
    end

    assign w_tick = (r_ps == PS_BITS'(PRESCALE - 1));
    assign w_wrap = w_tick && (r_pwm_cnt == PWM_CNT_BITS'(PWM_STEPS - 1));

    // Shared prescaler and PWM step counter
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_ps      <= '0;
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_ps <= '0;
            if (w_wrap) begin
                r_pwm_cnt <= '0;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + PWM_CNT_BITS'(1);
            end
        end else begin
            r_ps <= r_ps + PS_BITS'(1);
        end
    end

`ifdef LED_FADE_EN
    localparam int FD_BITS = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    logic [FD_BITS-1:0] r_fade_cnt;

    assign w_fade_step = w_wrap && (r_fade_cnt == FD_BITS'(FADE_DIV - 1));

    // Counts PWM periods between fade steps; writes never restart it
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_fade_cnt <= '0;
        end else if (w_wrap) begin
            if (r_fade_cnt == FD_BITS'(FADE_DIV - 1)) begin
                r_fade_cnt <= '0;
            end else begin
                r_fade_cnt <= r_fade_cnt + FD_BITS'(1);
            end
        end
    end
`else
    localparam int unused_fade_div = FADE_DIV;
    assign w_fade_step = 1'b0;
`endif

    // Per-LED channels
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_ctrl_pwm_channel u_ch (
            .sysclk      (sysclk),
            .rst_n       (rst_n),
            .i_wr_en     (w_commit_wr && (r_addr == ADDR_BITS'(g))),
            .i_wr_level  (w_wr_level),
            .i_pwm_cnt   (r_pwm_cnt),
            .i_fade_step (w_fade_step),
            .o_target    (w_target[g]),
            .o_led       (w_led[g])
        );
    end

    // Zero-latency read-back of the addressed target
    always_comb begin
        w_tx_payload = 8'h00;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (i_addr == ADDR_BITS'(i)) begin
                w_tx_payload = w_target[i];
            end
        end
    end

    assign o_tx_payload = w_tx_payload;
    assign o_led        = w_led;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_rd_strobe  = r_rd_strobe;
    assign o_err        = r_err;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl. Build with LED_FADE_EN defined to add
// the fade checks (duty-cycle checks then apply only to the plain build).
`timescale 1ns/1ps
module tb_led_pwm_ctrl;
    import led_pwm_ctrl_pkg::*;

    localparam int NUM_LEDS   = 4;
    localparam int PRESCALE   = 2;
    localparam int FADE_DIV   = 1;
    localparam int PERIOD_CYC = PWM_STEPS * PRESCALE;

    // ---------------- clock / reset / DUT ----------------
    logic                    sysclk = 1'b0;
    logic                    rst_n  = 1'b0;
    logic [CMD_BITS-1:0]     i_cmd = '0;
    logic [ADDR_BITS-1:0]    i_addr = '0;
    logic [PAYLOAD_BITS-1:0] i_payload = '0;
    logic                    i_rx_dv = 1'b1;
    logic                    i_rd_bypass = 1'b0;
    logic                    i_rx_addr_dv = 1'b0;
    logic [7:0]              o_tx_payload;
    logic [NUM_LEDS-1:0]     o_led;
    logic                    o_wr_strobe;
    logic                    o_rd_strobe;
    logic                    o_err;
    logic [1:0]              o_dbg_state;

    always #4 sysclk = ~sysclk;

    led_pwm_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .PRESCALE (PRESCALE),
        .FADE_DIV (FADE_DIV)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .i_cmd        (i_cmd),
        .i_addr       (i_addr),
        .i_payload    (i_payload),
        .i_rx_dv      (i_rx_dv),
        .i_rd_bypass  (i_rd_bypass),
        .i_rx_addr_dv (i_rx_addr_dv),
        .o_tx_payload (o_tx_payload),
        .o_led        (o_led),
        .o_wr_strobe  (o_wr_strobe),
        .o_rd_strobe  (o_rd_strobe),
        .o_err        (o_err),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    int         cnt_wr, cnt_rd, cnt_err;
    int         duty [NUM_LEDS];
    logic [7:0] exp_target [NUM_LEDS];
    logic [7:0] tx_seen;
    logic [31:0] exp_q [$];
    logic [31:0] run_q [$];
    logic        mon_en = 1'b0;
    int          run_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sysclk);
        #1;
        cnt_wr  += int'(o_wr_strobe);
        cnt_rd  += int'(o_rd_strobe);
        cnt_err += int'(o_err);
    endtask

    task automatic clear_counts();
        cnt_wr = 0; cnt_rd = 0; cnt_err = 0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] payload, input int low_cycles);
        clear_counts();
        i_rx_dv   = 1'b0;
        i_cmd     = cmd;
        i_addr    = addr;
        i_payload = payload;
        repeat (low_cycles) tick();
        i_rx_dv = 1'b1;
        repeat (6) tick();
    endtask

    task automatic read_frame(input logic [7:0] addr);
        clear_counts();
        i_rx_dv      = 1'b0;
        i_cmd        = CMD_LED_READ;
        i_rd_bypass  = 1'b1;
        i_addr       = addr;
        i_rx_addr_dv = 1'b0;
        repeat (10) tick();
        i_rx_addr_dv = 1'b1;
        #1;
        tx_seen = o_tx_payload;
        repeat (10) tick();
        i_rx_dv = 1'b1;
        repeat (6) tick();
        i_rx_addr_dv = 1'b0;
        i_rd_bypass  = 1'b0;
    endtask

    task automatic check_reads(input string tag);
        for (int i = 0; i < NUM_LEDS; i++) begin
            i_addr = 8'(i);
            #1;
            check($sformatf("%s_a%0d", tag, i), 32'(o_tx_payload), 32'(exp_target[i]));
        end
    endtask

    task automatic measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) duty[i] = 0;
        repeat (PERIOD_CYC) begin
            @(posedge sysclk);
            #1;
            for (int i = 0; i < NUM_LEDS; i++) duty[i] += int'(o_led[i]);
        end
    endtask

    // High-run lengths of LED 0, recorded while mon_en is set
    always @(negedge sysclk) begin
        if (mon_en) begin
            if (o_led[0]) begin
                run_len++;
            end else if (run_len != 0) begin
                run_q.push_back(32'(run_len));
                run_len = 0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NUM_LEDS; i++) exp_target[i] = 8'd0;

        // Reset held 5 cycles with rx_dv idle-high
        rst_n   = 1'b0;
        i_rx_dv = 1'b1;
        repeat (5) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        clear_counts();
        repeat (5) tick();
        check("rst_led", 32'(o_led), 32'd0);
        check("rst_wr", 32'(cnt_wr), 32'd0);
        check("rst_rd", 32'(cnt_rd), 32'd0);
        check("rst_err", 32'(cnt_err), 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        check_reads("rst_tx");

`ifdef LED_FADE_EN
        // Fade from 0 to 3 with one step per PWM period
        mon_en = 1'b1;
        send_frame(CMD_LED_SET, 8'd0, 8'd3, 5);
        exp_target[0] = 8'd3;
        check("fade_wr", 32'(cnt_wr), 32'd1);
        i_addr = 8'd0;
        #1;
        check("fade_read_now", 32'(o_tx_payload), 32'd3);
        repeat (5 * PERIOD_CYC) @(posedge sysclk);
        #1;
        mon_en = 1'b0;
        exp_q = '{32'(1 * PRESCALE), 32'(2 * PRESCALE), 32'(3 * PRESCALE), 32'(3 * PRESCALE)};
        check("fade_runs", 32'(run_q.size() >= exp_q.size()), 32'd1);
        while (exp_q.size() != 0 && run_q.size() != 0) begin
            check("fade_run_len", run_q.pop_front(), exp_q.pop_front());
        end
`endif

        // Write addr 2 = 50 after a long frame
        send_frame(CMD_LED_SET, 8'd2, 8'd50, 30);
        exp_target[2] = 8'd50;
        check("wr50_strobe", 32'(cnt_wr), 32'd1);
        check("wr50_err", 32'(cnt_err), 32'd0);
        check_reads("wr50_tx");
`ifndef LED_FADE_EN
        measure_duty();
        check("wr50_duty2", 32'(duty[2]), 32'(50 * PRESCALE));
        check("wr50_duty0", 32'(duty[0]), 32'd0);
        check("wr50_duty1", 32'(duty[1]), 32'd0);
        check("wr50_duty3", 32'(duty[3]), 32'd0);
`endif

        // Clamp: 200 percent saturates at 100
        send_frame(CMD_LED_SET, 8'd1, 8'd200, 8);
        exp_target[1] = 8'd100;
        check("clamp_strobe", 32'(cnt_wr), 32'd1);
        check_reads("clamp_tx");
`ifndef LED_FADE_EN
        measure_duty();
        check("clamp_duty1", 32'(duty[1]), 32'(PERIOD_CYC));
        check("clamp_duty2", 32'(duty[2]), 32'(50 * PRESCALE));
`endif

        // Out-of-range SET: error, no write
        send_frame(CMD_LED_SET, 8'd7, 8'd33, 8);
        check("badaddr_err", 32'(cnt_err), 32'd1);
        check("badaddr_wr", 32'(cnt_wr), 32'd0);
        check_reads("badaddr_tx");
        i_addr = 8'd7;
        #1;
        check("badaddr_tx7", 32'(o_tx_payload), 32'd0);

        // Unknown command: error, no write
        send_frame(8'h5A, 8'd0, 8'd77, 8);
        check("unk_err", 32'(cnt_err), 32'd1);
        check("unk_wr", 32'(cnt_wr), 32'd0);

        // NOP: silent
        send_frame(CMD_NOP, 8'd0, 8'd77, 8);
        check("nop_err", 32'(cnt_err), 32'd0);
        check("nop_wr", 32'(cnt_wr), 32'd0);
        check_reads("nop_tx");

        // Read: preload addr 3 = 75, then read it back
        send_frame(CMD_LED_SET, 8'd3, 8'd75, 8);
        exp_target[3] = 8'd75;
        check("pre75_strobe", 32'(cnt_wr), 32'd1);
        read_frame(8'd3);
        check("rd3_tx", 32'(tx_seen), 32'd75);
        check("rd3_rd", 32'(cnt_rd), 32'd1);
        check("rd3_wr", 32'(cnt_wr), 32'd0);
        check("rd3_err", 32'(cnt_err), 32'd0);

        // Read of an out-of-range address
        read_frame(8'd6);
        check("rd6_tx", 32'(tx_seen), 32'd0);
        check("rd6_rd", 32'(cnt_rd), 32'd1);
        check("rd6_err", 32'(cnt_err), 32'd1);
        check_reads("rd_tx");

        // Truncated frame still commits a valid SET
        send_frame(CMD_LED_SET, 8'd0, 8'd10, 2);
        exp_target[0] = 8'd10;
        check("trunc_wr", 32'(cnt_wr), 32'd1);
        check_reads("trunc_tx");

        // Reset in the middle of a frame discards it
        clear_counts();
        i_rx_dv   = 1'b0;
        i_cmd     = CMD_LED_SET;
        i_addr    = 8'd0;
        i_payload = 8'd60;
        repeat (10) tick();
        check("mid_busy", 32'(o_dbg_state), 32'd1);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clear_counts();
        repeat (3) tick();
        i_rx_dv = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < NUM_LEDS; i++) exp_target[i] = 8'd0;
        check("mid_wr", 32'(cnt_wr), 32'd0);
        check("mid_err", 32'(cnt_err), 32'd0);
        check("mid_led", 32'(o_led), 32'd0);
        check_reads("mid_tx");

        // Normal operation resumes after the discarded frame
        send_frame(CMD_LED_SET, 8'd2, 8'd1, 6);
        exp_target[2] = 8'd1;
        check("post_wr", 32'(cnt_wr), 32'd1);
        check_reads("post_tx");
`ifndef LED_FADE_EN
        measure_duty();
        check("post_duty2", 32'(duty[2]), 32'(PRESCALE));
        check("post_duty0", 32'(duty[0]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
